// File: rtl/life_board_stepper_if.sv
// Control/readout bundle for life_board_stepper: load/start requests in,
// committed board and step status out.
interface life_board_stepper_if #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned GEN_W = 16
);
  localparam int unsigned CELLS = ROWS * COLS;

  logic             load;
  logic [CELLS-1:0] init_state;
  logic             start;
  logic [CELLS-1:0] cells;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] generation;

  modport master (
    output load, init_state, start,
    input  cells, busy, done, generation
  );

  modport slave (
    input  load, init_state, start,
    output cells, busy, done, generation
  );
endinterface

// File: rtl/life_board_stepper.sv
// Game of Life board on a torus: one cell evaluated per cycle into a shadow
// buffer, whole board committed in a single cycle at the end of the scan.
module life_board_stepper #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  life_board_stepper_if.slave  bus
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned IDX_W = $clog2(CELLS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CELLS-1:0] cells_q,  cells_d;
  logic [CELLS-1:0] shadow_q, shadow_d;
  logic [ROW_W-1:0] row_q,    row_d;
  logic [COL_W-1:0] col_q,    col_d;
  logic [GEN_W-1:0] gen_q,    gen_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [ROW_W-1:0] row_up, row_dn;
  logic [COL_W-1:0] col_lf, col_rt;
  logic [3:0]       count;
  logic             alive;
  logic             next_alive;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c);
    return IDX_W'(32'(r) * COLS + 32'(c));
  endfunction

  // Toroidal neighbour coordinates of the scan position
  always_comb begin
    row_up = (row_q == '0) ? ROW_W'(ROWS - 1) : row_q - ROW_W'(1);
    row_dn = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    col_lf = (col_q == '0) ? COL_W'(COLS - 1) : col_q - COL_W'(1);
    col_rt = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
  end

  // Neighbour count and Conway rule, always against the committed board
  always_comb begin
    count = 4'(cells_q[cell_idx(row_up, col_lf)])
          + 4'(cells_q[cell_idx(row_up, col_q )])
          + 4'(cells_q[cell_idx(row_up, col_rt)])
          + 4'(cells_q[cell_idx(row_q,  col_lf)])
          + 4'(cells_q[cell_idx(row_q,  col_rt)])
          + 4'(cells_q[cell_idx(row_dn, col_lf)])
          + 4'(cells_q[cell_idx(row_dn, col_q )])
          + 4'(cells_q[cell_idx(row_dn, col_rt)]);
    alive      = cells_q[cell_idx(row_q, col_q)];
    next_alive = (count == 4'd3) || (alive && (count == 4'd2));
  end

  always_comb begin
    state_d  = state_q;
    cells_d  = cells_q;
    shadow_d = shadow_q;
    row_d    = row_q;
    col_d    = col_q;
    gen_d    = gen_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          cells_d = bus.init_state;
          gen_d   = '0;
        end else if (bus.start) begin
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        shadow_d[cell_idx(row_q, col_q)] = next_alive;
        if (col_q == COL_W'(COLS - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(ROWS - 1)) state_d = S_COMMIT;
          else                           row_d   = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      S_COMMIT: begin
        cells_d = shadow_q;
        gen_d   = gen_q + GEN_W'(1);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cells_q  <= '0;
      shadow_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      gen_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cells_q  <= cells_d;
      shadow_q <= shadow_d;
      row_q    <= row_d;
      col_q    <= col_d;
      gen_q    <= gen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.cells      = cells_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.generation = gen_q;

endmodule

// File: tb/tb_life_board_stepper.sv
// Directed bench for life_board_stepper: a generation-level Life model is
// compared every cycle, with hand-computed boards pinning the model.
module tb_life_board_stepper;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned GEN_W = 16;
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = 6;

  localparam logic [63:0] HORIZ   = 64'h0000_0000_1C00_0000; // (3,2),(3,3),(3,4)
  localparam logic [63:0] VERT    = 64'h0000_0008_0808_0000; // (2,3),(3,3),(4,3)
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303; // (0,0),(0,1),(1,0),(1,1)
  localparam logic [63:0] GLIDER  = 64'hE080_4000_0000_0000; // (5,6),(6,7),(7,5..7)
  localparam logic [63:0] GLIDER4 = 64'h0180_0000_0000_00C1; // glider moved by (+1,+1)
  localparam logic [63:0] ALT     = 64'hA5A5_0F0F_3C3C_9999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  life_board_stepper_if #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) bus ();

  life_board_stepper #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference Life step on a torus, straight from the rules
  function automatic logic [N-1:0] life_step(input logic [N-1:0] b);
    logic [N-1:0] nb;
    int R, C, n, rr, cc;
    logic live;
    nb = '0;
    R = int'(ROWS);
    C = int'(COLS);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = (r + dr + R) % R;
              cc = (c + dc + C) % C;
              n += int'(b[IDX_W'(rr * C + cc)]);
            end
          end
        end
        live = b[IDX_W'(r * C + c)];
        nb[IDX_W'(r * C + c)] = (n == 3) || (live && n == 2);
      end
    end
    return nb;
  endfunction

  // Timing model: a step takes N scan cycles then one commit cycle
  logic [N-1:0]     m_cells = '0;
  logic [GEN_W-1:0] m_gen   = '0;
  logic             m_busy  = 1'b0;
  logic             m_done  = 1'b0;
  int               m_cnt   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_cells <= '0;
      m_gen   <= '0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_cnt   <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == int'(N)) begin
          m_cells <= life_step(m_cells);
          m_gen   <= m_gen + GEN_W'(1);
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (bus.load) begin
        m_cells <= bus.init_state;
        m_gen   <= '0;
      end else if (bus.start) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cells",      64'(bus.cells),      64'(m_cells));
      check("busy",       64'(bus.busy),       64'(m_busy));
      check("done",       64'(bus.done),       64'(m_done));
      check("generation", 64'(bus.generation), 64'(m_gen));
    end
  end

  task automatic load_board(input logic [N-1:0] p);
    bus.init_state = p;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(bus.done), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load = 1'b0;
    bus.start = 1'b0;
    bus.init_state = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_cells", 64'(bus.cells), 64'd0);
    check("rst_busy",  64'(bus.busy),  64'd0);
    check("rst_done",  64'(bus.done),  64'd0);
    check("rst_gen",   64'(bus.generation), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Blinker: two steps
    load_board(HORIZ);
    check("blink_loaded", 64'(bus.cells), HORIZ);
    pulse_start();
    check("blink_busy", 64'(bus.busy), 64'd1);
    wait_done();
    check("blink_vert", 64'(bus.cells), VERT);
    check("blink_gen1", 64'(bus.generation), 64'd1);
    check("blink_notbusy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("blink_done_pulse", 64'(bus.done), 64'd0);
    pulse_start();
    wait_done();
    check("blink_horiz", 64'(bus.cells), HORIZ);
    check("blink_gen2", 64'(bus.generation), 64'd2);

    // Block still life in the wrap corner
    load_board(BLOCK);
    pulse_start();
    wait_done();
    check("block_same", 64'(bus.cells), BLOCK);
    check("block_corner77", 64'(bus.cells[63]), 64'd0);
    check("block_corner70", 64'(bus.cells[56]), 64'd0);
    check("block_corner07", 64'(bus.cells[7]), 64'd0);

    // Glider around the torus
    load_board(GLIDER);
    for (int s = 0; s < 32; s++) begin
      pulse_start();
      wait_done();
      if (s == 3) check("glider_step4", 64'(bus.cells), GLIDER4);
    end
    check("glider_back", 64'(bus.cells), GLIDER);
    check("glider_gen32", 64'(bus.generation), 64'd32);

    // start held high: two back-to-back steps
    load_board(HORIZ);
    bus.start = 1'b1;
    wait_done();
    @(negedge clk);
    check("held_rebusy", 64'(bus.busy), 64'd1);
    wait_done();
    bus.start = 1'b0;
    check("held_horiz", 64'(bus.cells), HORIZ);
    check("held_gen2", 64'(bus.generation), 64'd2);
    @(negedge clk);
    check("held_idle", 64'(bus.busy), 64'd0);

    // load/start ignored mid-scan
    load_board(HORIZ);
    pulse_start();
    repeat (9) @(negedge clk);
    bus.init_state = '1;
    bus.load = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bus.start = 1'b0;
    check("scan_cells_hold", 64'(bus.cells), HORIZ);
    wait_done();
    check("ign_vert", 64'(bus.cells), VERT);
    check("ign_gen1", 64'(bus.generation), 64'd1);
    repeat (3) @(negedge clk);
    check("ign_single_done", 64'(bus.done), 64'd0);

    // load and start together in IDLE: load wins
    bus.init_state = ALT;
    bus.load = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bus.start = 1'b0;
    check("ls_cells", 64'(bus.cells), ALT);
    check("ls_busy",  64'(bus.busy), 64'd0);
    check("ls_gen",   64'(bus.generation), 64'd0);
    repeat (3) @(negedge clk);
    check("ls_still_idle", 64'(bus.busy), 64'd0);

    // Reset mid-scan aborts the step
    load_board(HORIZ);
    pulse_start();
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_cells", 64'(bus.cells), 64'd0);
    check("mrst_busy",  64'(bus.busy), 64'd0);
    check("mrst_done",  64'(bus.done), 64'd0);
    check("mrst_gen",   64'(bus.generation), 64'd0);
    load_board(HORIZ);
    pulse_start();
    wait_done();
    check("mrst_after", 64'(bus.cells), VERT);
    check("mrst_gen1",  64'(bus.generation), 64'd1);
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/life_board_stepper.md
Name: life_board_stepper

Overview:
- Sequential consumer of 8-neighbour counts: holds a ROWS x COLS Game of Life board and advances it one generation per start request.
- Scans cells one per cycle, counts the eight toroidal neighbours of the current board, applies the Conway rule into a shadow buffer, then commits the whole board in one cycle.
- Sits between the board-load/control logic and the display/readout path.

Parameters:
- ROWS, 8, board height in cells (>=3)
- COLS, 8, board width in cells (>=3)
- GEN_W, 16, width of generation counter

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  copy init_state into board (honoured only in IDLE)
- init_state  input  ROWS*COLS  initial board; cell (r,c) at bit r*COLS+c
- start  input  1  request one generation step (honoured only in IDLE)
- cells  output  ROWS*COLS  current committed board, same bit mapping
- busy  output  1  high while a step is in progress
- done  output  1  one-cycle pulse when a new generation is committed
- generation  output  GEN_W  number of steps committed since last load/reset

Behaviour:
- Reset: synchronous, active-high; cells=0, shadow=0, generation=0, busy=0, done=0, scan index=0, state=IDLE. Reset in any state, including mid-SCAN, aborts the step; no partial commit.
- States: IDLE, SCAN, COMMIT.
- IDLE: done=0 except its post-COMMIT pulse cycle. If load=1: cells<=init_state, generation<=0, stay IDLE; start ignored that cycle (load wins). Else if start=1: index<=0, busy<=1, ->SCAN.
- SCAN: each cycle evaluates cell at index i (r=i/COLS, c=i%COLS) against committed cells only (never shadow).
  - Neighbours: (r+-1, c+-1) with toroidal wrap (row -1 -> ROWS-1, row ROWS -> 0; same for columns). Cell itself excluded.
  - Count: 4-bit unsigned, range 0..8, no overflow.
  - Next state: alive if count==3, or (cell alive and count==2); else dead.
  - shadow[i]<=next state; index<=i+1. When i==ROWS*COLS-1: ->COMMIT.
  - load and start ignored; cells unchanged throughout SCAN.
- COMMIT: one cycle; cells<=shadow, generation<=generation+1 (wraps 2^GEN_W-1 -> 0), busy<=0, done<=1, ->IDLE.
- Timing: start sampled at edge E0 -> busy=1 after E0; new cells, done=1, busy=0 visible after edge E0+ROWS*COLS+1; done returns to 0 after next edge. Step latency = ROWS*COLS+1 cycles.
- start held high continuously: next step accepted on the IDLE cycle where done=1; steps back-to-back with one idle cycle between.
- done and busy never both high.

Test Plan:
- Blinker: load bits (3,2),(3,3),(3,4) on 8x8, pulse start -> after 65 cycles cells = (2,3),(3,3),(4,3) only; done high exactly 1 cycle; generation=1; second step restores horizontal, generation=2.
- Block still life: load (0,0),(0,1),(1,0),(1,1) -> cells unchanged after step; verifies corner wrap does not spuriously add neighbours (cells (7,7),(7,0),(0,7) stay dead).
- Toroidal glider: load glider near bottom-right corner, run 32 steps -> pattern returns to initial cells shifted by (+8,+8) mod 8 = initial board; generation=32.
- Ignored controls: start, then pulse load with alternate pattern and re-pulse start at cycle 10 of SCAN -> result equals blinker step only; cells unchanged during SCAN; single done.
- Load/start same cycle in IDLE -> board = init_state, busy stays 0, generation=0, no done.
- Reset at cycle 30 of SCAN -> cells=0, busy=0, done=0, generation=0 next cycle; later load+start works normally.
